// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift out
// one byte with odd parity, check the device ack, guarded by a watchdog.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 1500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t        state;
  logic [2:0]    clk_sync;
  logic [1:0]    data_sync;
  logic [9:0]    shreg;
  logic [3:0]    bit_cnt;
  logic [IW-1:0] inh_cnt;
  logic [WW-1:0] wd_cnt;

  logic fall;
  logic clk_s;
  logic data_s;
  logic inh_last;
  logic wd_on;
  logic wd_fire;

  assign fall     = !clk_sync[1] && clk_sync[2];
  assign clk_s    = clk_sync[1];
  assign data_s   = data_sync[1];
  assign inh_last = inh_cnt == IW'(INHIBIT_CYCLES - 1);
  assign wd_on    = state inside {SEND, ACK, WAIT_IDLE};
  assign wd_fire  = wd_on && !fall &&
                    (wd_cnt == WW'(TIMEOUT_CYCLES - 1));

  // Idle PS/2 lines are pulled up, so synchronisers reset high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      inh_cnt     <= '0;
      wd_cnt      <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
      tx_ready    <= 1'b1;
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      if (!wd_on || fall) wd_cnt <= '0;
      else                wd_cnt <= wd_cnt + WW'(1);

      if (wd_fire) begin
        ps2_clk_oe  <= 1'b0;
        ps2_data_oe <= 1'b0;
        tx_err      <= 1'b1;
        busy        <= 1'b0;
        wd_cnt      <= '0;
        state       <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            tx_ready    <= 1'b1;
            inh_cnt     <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            if (tx_valid && tx_ready) begin
              shreg      <= {1'b1, ~^tx_data, tx_data};
              busy       <= 1'b1;
              tx_ready   <= 1'b0;
              ps2_clk_oe <= 1'b1;
              state      <= INHIBIT;
            end
          end
          INHIBIT: begin
            if (inh_last) begin
              ps2_data_oe <= 1'b1;
              state       <= REQ;
            end else begin
              inh_cnt <= inh_cnt + IW'(1);
            end
          end
          REQ: begin
            ps2_clk_oe <= 1'b0;
            bit_cnt    <= '0;
            state      <= SEND;
          end
          SEND: begin
            if (fall) begin
              ps2_data_oe <= ~shreg[0];
              shreg       <= {1'b1, shreg[9:1]};
              bit_cnt     <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd9) state <= ACK;
            end
          end
          ACK: begin
            if (fall) begin
              if (!data_s) begin
                state <= WAIT_IDLE;
              end else begin
                tx_err <= 1'b1;
                busy   <= 1'b0;
                state  <= IDLE;
              end
            end
          end
          WAIT_IDLE: begin
            if (clk_s && data_s) begin
              tx_done <= 1'b1;
              busy    <= 1'b0;
              state   <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
